hline_wr_sched: RTL and testbench
=================================

Name: hline_wr_sched

Overview:
- Write-side scheduler for the 29-bit tagged pixel FIFO. The FIFO is checked downstream by the frame checker.
- Shares the single FIFO write port between two half-line sources: source 0 carries x=0 and source 1 carries x=1.
- Grants each source in fixed 640-word bursts, alternating x=0 then x=1 on every line, and stamps {x,y} onto each word.
- Guarantees the ordering downstream expects: 640 words per half, y increments after x=1, and y wraps after line 719.

Parameters:
- WORDS_PER_HALF, 640, words per half-line burst
- LINES, 720, lines per frame
- DATA_W, 16, pixel data width

Ports:
- clk125m  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse; (re)starts the frame at x=0, y=0
- s0_valid  in  1  source 0 word available
- s0_data  in  DATA_W  source 0 word
- s0_ready  out  1  source 0 word accepted this cycle when s0_valid is also high
- s1_valid  in  1  source 1 word available
- s1_data  in  DATA_W  source 1 word
- s1_ready  out  1  source 1 word accepted this cycle when s1_valid is also high
- fifo_full  in  1  FIFO programmable-full; must assert with at least 1 free slot remaining
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  29  {x[1:0], y[10:0], data[15:0]}; x occupies bits 28:27, y bits 26:16
- busy  out  1  frame in progress
- frame_done  out  1  1-cycle pulse after the last word of line LINES-1, x=1
- frame_abort  out  1  sticky; set when frame_start arrives while busy

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state IDLE; word count 0; x 0; y 0
  - fifo_wr_en 0; fifo_din 0; busy 0; frame_done 0; frame_abort 0
- States: IDLE, BURST0, BURST1.
- IDLE:
  - s0_ready = s1_ready = 0.
  - frame_start -> BURST0, y=0, count=0.
- BURSTk:
  - sk_ready = !fifo_full && !frame_start.
  - The other source's ready is 0.
- Transfer occurs when sk_valid && sk_ready.
- On a transfer, the next cycle registers fifo_wr_en=1 and fifo_din={k, y, sk_data}. Latency is 1 cycle; there is no other pipeline stage.
- With no transfer in a cycle, fifo_wr_en=0 next cycle and fifo_din holds its last value.
- Word count increments per transfer. On the transfer with count==WORDS_PER_HALF-1:
  - count goes to 0.
  - BURST0 -> BURST1, y unchanged.
  - BURST1 with y != LINES-1 -> BURST0, y+1.
  - BURST1 with y == LINES-1 -> IDLE, y=0, frame_done pulses the next cycle (aligned with the final fifo_wr_en).
- y arithmetic is 11-bit and never exceeds LINES-1.
- A stalled burst (valid low or fifo_full high) holds its state and count indefinitely. There is no timeout.
- frame_start while in a BURST state:
  - No transfer that cycle, because ready is forced low.
  - frame_abort sets.
  - Next state is BURST0, count=0, y=0. The partial half-line is abandoned; the downstream checker's WAIT state resynchronises.
- frame_start coinciding with the last word of a frame: the word is not accepted (ready is low), and the abort rule applies.
- busy = (state != IDLE), registered with the state.
- frame_abort clears only on reset.
- Sources never see ready high while their valid is low-gated. There is no combinational path from valid to ready.

Optional Feature:
- Macro: HLINE_WR_SCHED_STALL_CNT_EN
- Defined:
  - Adds output stall_count (16 bits): a saturating count of cycles in a BURST state where sk_valid=1 and fifo_full=1.
  - Reset value 0; holds at 16'hFFFF once saturated.
  - Clears on frame_start.
- Undefined: port absent and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package hline_pkg:
  - field positions: X_MSB=28, X_LSB=27, Y_MSB=26, Y_LSB=16, DATA_MSB=15
  - TAG_W=29
  - state encoding constants: IDLE=2'h0, BURST0=2'h1, BURST1=2'h2
- One natural sub-module, hline_pos_counter:
  - holds count, x and y
  - inputs: step, restart
  - outputs: last_word, last_line
- The scheduler FSM, ready gating and output register stay in hline_wr_sched.

Test Plan:
- Reset, frame_start, both sources always valid, fifo_full=0 -> 921600 writes; first fifo_din=29'h0000_xxxx (x=0, y=0); word 640 carries x=1, y=0; word 1281 carries x=0, y=1; last word x=1, y=719; frame_done 1 cycle after it; busy falls.
- s0_valid low after 100 words for 50 cycles -> no writes, count held; resume -> 640 total x=0 words; s1_ready never high during BURST0.
- fifo_full held high for 20 cycles mid-burst -> s0_ready=0 and no fifo_wr_en for those cycles; no words lost or duplicated (data pattern = incrementing counter, checked contiguous).
- frame_start at y=5, x=1, count=300 -> no write that cycle; frame_abort=1; next write x=0, y=0; frame_abort stays 1 until reset.
- Reset asserted mid-burst (asynchronous, between edges) -> fifo_wr_en, busy and frame_abort drop to 0 immediately; s0_ready=0 until the next frame_start.
- With HLINE_WR_SCHED_STALL_CNT_EN defined: s0_valid=1 and fifo_full=1 for 70000 cycles -> stall_count=16'hFFFF; frame_start -> 0.

Source files
------------

// File: rtl/hline_pkg.sv
// rtl/hline_pkg.sv - field layout, state encoding and tag packing for the hline write scheduler
package hline_pkg;

   localparam int TAG_W    = 29;
   localparam int X_MSB    = 28;
   localparam int X_LSB    = 27;
   localparam int Y_MSB    = 26;
   localparam int Y_LSB    = 16;
   localparam int DATA_MSB = 15;
   localparam int Y_W      = Y_MSB - Y_LSB + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'h0,
      BURST0 = 2'h1,
      BURST1 = 2'h2
   } state_e;

   function automatic logic [TAG_W-1:0] pack_tag(input logic x, input logic [Y_W-1:0] y,
                                                 input logic [DATA_MSB:0] data);
      logic [TAG_W-1:0] tag;
      tag                  = '0;
      tag[X_MSB:X_LSB]     = {1'b0, x};
      tag[Y_MSB:Y_LSB]     = y;
      tag[DATA_MSB:0]      = data;
      return tag;
   endfunction

endpackage

// File: rtl/hline_wr_sched_if.sv
// rtl/hline_wr_sched_if.sv - source, FIFO and status signals of the hline write scheduler
interface hline_wr_sched_if #(
   parameter int DATA_W = 16
);
   import hline_pkg::*;

   logic              frame_start;
   logic              s0_valid;
   logic [DATA_W-1:0] s0_data;
   logic              s0_ready;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic              s1_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [TAG_W-1:0]  fifo_din;
   logic              busy;
   logic              frame_done;
   logic              frame_abort;

   modport master (
      input  frame_start, s0_valid, s0_data, s1_valid, s1_data, fifo_full,
      output s0_ready, s1_ready, fifo_wr_en, fifo_din, busy, frame_done, frame_abort
   );

   modport slave (
      output frame_start, s0_valid, s0_data, s1_valid, s1_data, fifo_full,
      input  s0_ready, s1_ready, fifo_wr_en, fifo_din, busy, frame_done, frame_abort
   );

endinterface

// File: rtl/hline_pos_counter.sv
// rtl/hline_pos_counter.sv - word count, x and y position of the current half-line burst
module hline_pos_counter
   import hline_pkg::*;
#(
   parameter int WORDS_PER_HALF = 640,
   parameter int LINES          = 720,
   localparam int CNT_W         = $clog2(WORDS_PER_HALF)
) (
   input  logic           clk125m,
   input  logic           reset,
   input  logic           step_i,
   input  logic           restart_i,
   output logic           last_word_o,
   output logic           last_line_o,
   output logic           x_o,
   output logic [Y_W-1:0] y_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;

   assign last_word_o = (cnt_q == CNT_W'(WORDS_PER_HALF - 1));
   assign last_line_o = (y_q == Y_W'(LINES - 1));
   assign x_o         = x_q;
   assign y_o         = y_q;

   always_comb begin
      cnt_d = cnt_q;
      x_d   = x_q;
      y_d   = y_q;
      if (restart_i) begin
         cnt_d = '0;
         x_d   = 1'b0;
         y_d   = '0;
      end else if (step_i) begin
         if (last_word_o) begin
            cnt_d = '0;
            x_d   = ~x_q;
            // y advances only after the x=1 half and wraps after the last line
            if (x_q) y_d = last_line_o ? '0 : y_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk125m or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         x_q   <= 1'b0;
         y_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

endmodule

// File: rtl/hline_wr_sched.sv
// rtl/hline_wr_sched.sv - alternating x=0/x=1 burst scheduler onto the tagged pixel FIFO write port
// Optional stall_count output enabled by HLINE_WR_SCHED_STALL_CNT_EN.
module hline_wr_sched
   import hline_pkg::*;
#(
   parameter int WORDS_PER_HALF = 640,
   parameter int LINES          = 720,
   parameter int DATA_W         = 16
) (
   input  logic               clk125m,
   input  logic               reset,
   hline_wr_sched_if.master   bus
`ifdef HLINE_WR_SCHED_STALL_CNT_EN
   ,
   output logic [15:0]        stall_count
`endif
);

   state_e            state_q, state_d;
   logic              busy_q, wr_en_q, done_q, done_d, abort_q, abort_set;
   logic [TAG_W-1:0]  din_q;
   logic              s0_rdy, s1_rdy, transfer, restart;
   logic              act_valid;
   logic [DATA_W-1:0] act_data;
   logic              last_word, last_line, pos_x;
   logic [Y_W-1:0]    pos_y;

   // ready depends only on state, fifo_full and frame_start, never on valid
   assign s0_rdy    = (state_q == BURST0) && !bus.fifo_full && !bus.frame_start;
   assign s1_rdy    = (state_q == BURST1) && !bus.fifo_full && !bus.frame_start;
   assign act_valid = (state_q == BURST1) ? bus.s1_valid : bus.s0_valid;
   assign act_data  = (state_q == BURST1) ? bus.s1_data : bus.s0_data;
   assign transfer  = (s0_rdy && bus.s0_valid) || (s1_rdy && bus.s1_valid);

   hline_pos_counter #(
      .WORDS_PER_HALF (WORDS_PER_HALF),
      .LINES          (LINES)
   ) u_pos (
      .clk125m     (clk125m),
      .reset       (reset),
      .step_i      (transfer),
      .restart_i   (restart),
      .last_word_o (last_word),
      .last_line_o (last_line),
      .x_o         (pos_x),
      .y_o         (pos_y)
   );

   always_comb begin
      state_d   = state_q;
      restart   = 1'b0;
      abort_set = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.frame_start) begin
               state_d = BURST0;
               restart = 1'b1;
            end
         end
         BURST0, BURST1: begin
            if (bus.frame_start) begin
               state_d   = BURST0;
               restart   = 1'b1;
               abort_set = 1'b1;
            end else if (transfer && last_word) begin
               if (state_q == BURST0) begin
                  state_d = BURST1;
               end else if (last_line) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = BURST0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk125m or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         wr_en_q <= 1'b0;
         din_q   <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         wr_en_q <= transfer;
         if (transfer) din_q <= pack_tag(pos_x, pos_y, act_data);
         done_q  <= done_d;
         abort_q <= abort_q | abort_set;
      end
   end

   assign bus.s0_ready    = s0_rdy;
   assign bus.s1_ready    = s1_rdy;
   assign bus.fifo_wr_en  = wr_en_q;
   assign bus.fifo_din    = din_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = done_q;
   assign bus.frame_abort = abort_q;

`ifdef HLINE_WR_SCHED_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk125m or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (bus.frame_start) begin
         stall_q <= '0;
      end else if ((state_q != IDLE) && act_valid && bus.fifo_full && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_hline_wr_sched.sv
// tb/tb_hline_wr_sched.sv - scoreboard bench for hline_wr_sched on a reduced frame geometry
module tb_hline_wr_sched;
   import hline_pkg::*;

   localparam int W = 16;
   localparam int L = 8;

   typedef struct packed {
      logic [28:0] din;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hline_wr_sched_if #(.DATA_W(16)) bus();
`ifdef HLINE_WR_SCHED_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   hline_wr_sched #(
      .WORDS_PER_HALF (W),
      .LINES          (L),
      .DATA_W         (16)
   ) dut (
      .clk125m (clk),
      .reset   (rst),
      .bus     (bus)
`ifdef HLINE_WR_SCHED_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   exp_t        q[$];
   exp_t        me;
   int          checks = 0;
   int          errors = 0;
   int          m_state = 0;
   int          m_cnt = 0;
   int          m_y = 0;
   bit          m_abort = 1'b0;
   int          n_wr = 0;
   int          n_done = 0;
   logic [15:0] d0 = 16'h0;
   logic [15:0] d1 = 16'h8000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (!rst) begin
         if (bus.fifo_wr_en) begin
            n_wr++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got din %0h with no expected word", bus.fifo_din);
            end else begin
               me = q.pop_front();
               chk("fifo_din", bus.fifo_din, me.din);
               chk("frame_done", bus.frame_done, me.done);
            end
         end else begin
            chk("frame_done_no_write", bus.frame_done, 0);
         end
         if (bus.frame_done) n_done++;
         chk("busy", bus.busy, (m_state != 0));
         chk("frame_abort", bus.frame_abort, m_abort);
      end
   end

   task automatic cyc(input bit v0, input bit v1, input bit full, input bit fs);
      bit   e0, e1, xfer;
      exp_t e;
      @(negedge clk);
      bus.s0_valid    = v0;
      bus.s1_valid    = v1;
      bus.fifo_full   = full;
      bus.frame_start = fs;
      bus.s0_data     = d0;
      bus.s1_data     = d1;
      #1;
      e0 = (m_state == 1) && !full && !fs;
      e1 = (m_state == 2) && !full && !fs;
      chk("s0_ready", bus.s0_ready, e0);
      chk("s1_ready", bus.s1_ready, e1);
      xfer = (e0 && v0) || (e1 && v1);
      if (fs) begin
         if (m_state != 0) m_abort = 1'b1;
         m_state = 1;
         m_cnt   = 0;
         m_y     = 0;
      end else if (xfer) begin
         e.din  = {((m_state == 2) ? 2'd1 : 2'd0), 11'(m_y), ((m_state == 2) ? d1 : d0)};
         e.done = 1'b0;
         if (m_state == 1) d0++; else d1++;
         if (m_cnt == W - 1) begin
            m_cnt = 0;
            if (m_state == 1) begin
               m_state = 2;
            end else if (m_y == L - 1) begin
               m_state = 0;
               m_y     = 0;
               e.done  = 1'b1;
            end else begin
               m_state = 1;
               m_y++;
            end
         end else begin
            m_cnt++;
         end
         q.push_back(e);
      end
   endtask

   task automatic run_until_idle(input string name);
      for (int i = 0; i < 4 * W * L && m_state != 0; i++) cyc(1, 1, 0, 0);
      chk(name, m_state, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s0_valid    = 1'b0;
      bus.s1_valid    = 1'b0;
      bus.s0_data     = '0;
      bus.s1_data     = '0;
      bus.fifo_full   = 1'b0;
      bus.frame_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", bus.fifo_wr_en, 0);
      chk("rst_fifo_din", bus.fifo_din, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_frame_abort", bus.frame_abort, 0);
      chk("rst_s0_ready", bus.s0_ready, 0);
      chk("rst_s1_ready", bus.s1_ready, 0);
`ifdef HLINE_WR_SCHED_STALL_CNT_EN
      chk("rst_stall_count", stall_count, 0);
`endif
      rst = 1'b0;

      // full frame, both sources always valid
      n_wr = 0; n_done = 0;
      cyc(1, 1, 0, 1);
      run_until_idle("frame_complete");
      repeat (3) cyc(0, 0, 0, 0);
      chk("frame_writes", n_wr, 2 * W * L);
      chk("frame_done_count", n_done, 1);

      // valid gap and fifo_full stall inside the x=0 burst
      n_wr = 0;
      cyc(1, 1, 0, 1);
      for (int i = 0; i < W / 2; i++) cyc(1, 1, 0, 0);
      repeat (10) cyc(0, 1, 0, 0);
      repeat (W / 4) cyc(1, 1, 0, 0);
      repeat (6) cyc(1, 1, 1, 0);
      for (int i = 0; i < 4 * W && m_state == 1; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("half0_writes", n_wr, W);
      run_until_idle("stall_frame_complete");
      repeat (2) cyc(0, 0, 0, 0);

      // restart mid-frame at y=5, x=1, count=W/2
      n_done = 0;
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 4 * W * L && !(m_state == 2 && m_y == 5 && m_cnt == W / 2); i++)
         cyc(1, 1, 0, 0);
      chk("reach_abort_point", m_cnt, W / 2);
      cyc(1, 1, 0, 1);
      repeat (3) cyc(1, 1, 0, 0);

      // restart coinciding with the final word of the frame
      for (int i = 0; i < 4 * W * L && !(m_state == 2 && m_y == L - 1 && m_cnt == W - 1); i++)
         cyc(1, 1, 0, 0);
      chk("reach_last_word", m_cnt, W - 1);
      cyc(1, 1, 0, 1);
      repeat (2) cyc(0, 0, 0, 0);
      chk("abort_sticky", bus.frame_abort, 1);
      chk("no_done_on_abort", n_done, 0);

      // asynchronous reset between clock edges while writing
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      @(posedge clk);
      #3;
      chk("pre_reset_wr_en", bus.fifo_wr_en, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_wr_en", bus.fifo_wr_en, 0);
      chk("async_rst_busy", bus.busy, 0);
      chk("async_rst_abort", bus.frame_abort, 0);
      m_state = 0; m_cnt = 0; m_y = 0; m_abort = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) cyc(1, 1, 0, 0);

`ifdef HLINE_WR_SCHED_STALL_CNT_EN
      cyc(1, 0, 0, 1);
      for (int i = 0; i < 70000; i++) cyc(1, 0, 1, 0);
      chk("stall_count_saturated", stall_count, 16'hFFFF);
      cyc(1, 0, 1, 1);
      cyc(0, 0, 1, 0);
      chk("stall_count_cleared", stall_count, 0);
      run_until_idle("stall_cnt_frame_complete");
`endif

      repeat (3) cyc(0, 0, 0, 0);
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
